// File: rtl/md_unit.sv
// Multiply/divide unit: owns HI/LO, runs MULT/DIV-class ops with a fixed busy window and MTHI/MTLO in one cycle.
// Optional MADD/MADDU accumulate ops are compiled in when MDU_MADD_EN is defined.
module md_unit #(
   parameter int MULT_CYCLES = 5,
   parameter int DIV_CYCLES  = 10
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        start,
   input  logic [3:0]  md_op,
   input  logic        req,
   input  logic [31:0] A,
   input  logic [31:0] B,
   output logic        busy,
   output logic [31:0] HI,
   output logic [31:0] LO
);

   localparam int MAX_CYCLES = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
   localparam int CNT_W      = $clog2(MAX_CYCLES + 1);

   localparam logic [3:0] OP_MULT  = 4'd1;
   localparam logic [3:0] OP_MULTU = 4'd2;
   localparam logic [3:0] OP_DIV   = 4'd3;
   localparam logic [3:0] OP_DIVU  = 4'd4;
   localparam logic [3:0] OP_MTHI  = 4'd5;
   localparam logic [3:0] OP_MTLO  = 4'd6;
`ifdef MDU_MADD_EN
   localparam logic [3:0] OP_MADD  = 4'd7;
   localparam logic [3:0] OP_MADDU = 4'd8;
`endif

   typedef enum logic {
      S_IDLE = 1'b0,
      S_BUSY = 1'b1
   } state_t;

   state_t             r_state;
   logic [CNT_W-1:0]   r_cnt;
   logic               r_busy;
   logic [31:0]        r_hi;
   logic [31:0]        r_lo;
   logic [31:0]        r_hi_n;
   logic [31:0]        r_lo_n;
   logic               r_wr;

   state_t             w_state;
   logic [CNT_W-1:0]   w_cnt;
   logic               w_busy;
   logic [31:0]        w_hi;
   logic [31:0]        w_lo;
   logic [31:0]        w_hi_n;
   logic [31:0]        w_lo_n;
   logic               w_wr;

   // Products: low 64 bits of a 64x64 multiply of extended operands are exact.
   logic [63:0] w_a_sx;
   logic [63:0] w_b_sx;
   logic [63:0] w_prod_s;
   logic [63:0] w_prod_u;

   assign w_a_sx   = {{32{A[31]}}, A};
   assign w_b_sx   = {{32{B[31]}}, B};
   assign w_prod_s = w_a_sx * w_b_sx;
   assign w_prod_u = {32'd0, A} * {32'd0, B};

   // Divide on magnitudes, then restore signs; divisor forced to 1 when zero (result unused then).
   logic        w_b_zero;
   logic [31:0] w_b_div_u;
   logic [31:0] w_a_mag;
   logic [31:0] w_b_mag;
   logic [31:0] w_b_div_s;
   logic [31:0] w_q_mag;
   logic [31:0] w_r_mag;
   logic [31:0] w_quo_s;
   logic [31:0] w_rem_s;
   logic [31:0] w_quo_u;
   logic [31:0] w_rem_u;

   assign w_b_zero  = (B == 32'd0);
   assign w_b_div_u = w_b_zero ? 32'd1 : B;
   assign w_a_mag   = A[31] ? (32'd0 - A) : A;
   assign w_b_mag   = B[31] ? (32'd0 - B) : B;
   assign w_b_div_s = w_b_zero ? 32'd1 : w_b_mag;
   assign w_q_mag   = w_a_mag / w_b_div_s;
   assign w_r_mag   = w_a_mag % w_b_div_s;
   assign w_quo_s   = (A[31] ^ B[31]) ? (32'd0 - w_q_mag) : w_q_mag;
   assign w_rem_s   = A[31] ? (32'd0 - w_r_mag) : w_r_mag;
   assign w_quo_u   = A / w_b_div_u;
   assign w_rem_u   = A % w_b_div_u;

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_state <= S_IDLE;
         r_cnt   <= '0;
         r_busy  <= 1'b0;
         r_hi    <= 32'd0;
         r_lo    <= 32'd0;
         r_hi_n  <= 32'd0;
         r_lo_n  <= 32'd0;
         r_wr    <= 1'b0;
      end else begin
         r_state <= w_state;
         r_cnt   <= w_cnt;
         r_busy  <= w_busy;
         r_hi    <= w_hi;
         r_lo    <= w_lo;
         r_hi_n  <= w_hi_n;
         r_lo_n  <= w_lo_n;
         r_wr    <= w_wr;
      end
   end

   always_comb begin
      w_state = r_state;
      w_cnt   = r_cnt;
      w_busy  = r_busy;
      w_hi    = r_hi;
      w_lo    = r_lo;
      w_hi_n  = r_hi_n;
      w_lo_n  = r_lo_n;
      w_wr    = r_wr;
      case (r_state)
         S_IDLE: begin
            if (start && !req) begin
               case (md_op)
                  OP_MTHI: w_hi = A;
                  OP_MTLO: w_lo = A;
                  OP_MULT: begin
                     {w_hi_n, w_lo_n} = w_prod_s;
                     w_wr    = 1'b1;
                     w_cnt   = CNT_W'(MULT_CYCLES);
                     w_busy  = 1'b1;
                     w_state = S_BUSY;
                  end
                  OP_MULTU: begin
                     {w_hi_n, w_lo_n} = w_prod_u;
                     w_wr    = 1'b1;
                     w_cnt   = CNT_W'(MULT_CYCLES);
                     w_busy  = 1'b1;
                     w_state = S_BUSY;
                  end
                  OP_DIV: begin
                     w_hi_n  = w_rem_s;
                     w_lo_n  = w_quo_s;
                     w_wr    = !w_b_zero;
                     w_cnt   = CNT_W'(DIV_CYCLES);
                     w_busy  = 1'b1;
                     w_state = S_BUSY;
                  end
                  OP_DIVU: begin
                     w_hi_n  = w_rem_u;
                     w_lo_n  = w_quo_u;
                     w_wr    = !w_b_zero;
                     w_cnt   = CNT_W'(DIV_CYCLES);
                     w_busy  = 1'b1;
                     w_state = S_BUSY;
                  end
`ifdef MDU_MADD_EN
                  OP_MADD: begin
                     {w_hi_n, w_lo_n} = {r_hi, r_lo} + w_prod_s;
                     w_wr    = 1'b1;
                     w_cnt   = CNT_W'(MULT_CYCLES);
                     w_busy  = 1'b1;
                     w_state = S_BUSY;
                  end
                  OP_MADDU: begin
                     {w_hi_n, w_lo_n} = {r_hi, r_lo} + w_prod_u;
                     w_wr    = 1'b1;
                     w_cnt   = CNT_W'(MULT_CYCLES);
                     w_busy  = 1'b1;
                     w_state = S_BUSY;
                  end
`endif
                  default: ;
               endcase
            end
         end
         S_BUSY: begin
            // start and req are deliberately ignored here: the op in flight always completes.
            if (r_cnt == CNT_W'(1)) begin
               if (r_wr) begin
                  w_hi = r_hi_n;
                  w_lo = r_lo_n;
               end
               w_cnt   = '0;
               w_busy  = 1'b0;
               w_state = S_IDLE;
            end else begin
               w_cnt = r_cnt - CNT_W'(1);
            end
         end
         default: w_state = S_IDLE;
      endcase
   end

   assign busy = r_busy;
   assign HI   = r_hi;
   assign LO   = r_lo;

endmodule

// File: tb/tb_md_unit.sv
// Self-checking bench for md_unit: directed scenarios plus random ops against an arithmetic reference model.
module tb_md_unit;

   localparam int MC = 5;
   localparam int DC = 10;

   logic        clk;
   logic        reset;
   logic        start;
   logic [3:0]  md_op;
   logic        req;
   logic [31:0] A;
   logic [31:0] B;
   logic        busy;
   logic [31:0] HI;
   logic [31:0] LO;

   int checks   = 0;
   int failures = 0;

   logic [31:0] m_hi = 32'd0;
   logic [31:0] m_lo = 32'd0;

   md_unit #(.MULT_CYCLES(MC), .DIV_CYCLES(DC)) dut (
      .clk   (clk),
      .reset (reset),
      .start (start),
      .md_op (md_op),
      .req   (req),
      .A     (A),
      .B     (B),
      .busy  (busy),
      .HI    (HI),
      .LO    (LO)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   // Architectural result of one issued op, computed with plain 64-bit arithmetic.
   function automatic void model(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                                 input logic rq, output int cyc,
                                 output logic [31:0] nh, output logic [31:0] nl);
      longint            sa, sb, sp, q, r;
      longint unsigned   ua, ub, up, acc;
      nh  = m_hi;
      nl  = m_lo;
      cyc = 0;
      if (rq) return;
      sa  = int'(a);
      sb  = int'(b);
      ua  = {32'd0, a};
      ub  = {32'd0, b};
      sp  = sa * sb;
      up  = ua * ub;
      acc = {m_hi, m_lo};
      case (op)
         4'd1: begin nh = sp[63:32]; nl = sp[31:0]; cyc = MC; end
         4'd2: begin nh = up[63:32]; nl = up[31:0]; cyc = MC; end
         4'd3: begin
            cyc = DC;
            if (b != 0) begin
               q = sa / sb;
               r = sa % sb;
               nh = r[31:0];
               nl = q[31:0];
            end
         end
         4'd4: begin
            cyc = DC;
            if (b != 0) begin
               nh = a % b;
               nl = a / b;
            end
         end
         4'd5: nh = a;
         4'd6: nl = a;
`ifdef MDU_MADD_EN
         4'd7: begin acc = acc + longint'(sp); nh = acc[63:32]; nl = acc[31:0]; cyc = MC; end
         4'd8: begin acc = acc + up;           nh = acc[63:32]; nl = acc[31:0]; cyc = MC; end
`endif
         default: ;
      endcase
   endfunction

   task automatic run_op(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                         input logic rq, input bit poke);
      int          exp_cyc;
      int          cyc;
      logic [31:0] nh, nl;
      model(op, a, b, rq, exp_cyc, nh, nl);
      @(negedge clk);
      start = 1'b1; md_op = op; A = a; B = b; req = rq;
      @(negedge clk);
      start = 1'b0; md_op = 4'd0; req = 1'b0; A = $urandom; B = $urandom;
      cyc = 0;
      while (busy === 1'b1 && cyc < 40) begin
         chk("hold_hi", HI, m_hi);
         chk("hold_lo", LO, m_lo);
         if (poke && cyc == 1) begin
            start = 1'b1;
            md_op = 4'($urandom_range(1, 8));
            A     = $urandom;
            B     = $urandom;
            req   = 1'($urandom_range(0, 1));
         end else begin
            start = 1'b0;
            md_op = 4'd0;
            req   = (cyc == 2);
         end
         cyc++;
         @(negedge clk);
      end
      start = 1'b0; req = 1'b0;
      chk("busy_cycles", 32'(cyc), 32'(exp_cyc));
      m_hi = nh;
      m_lo = nl;
      chk("result_hi", HI, m_hi);
      chk("result_lo", LO, m_lo);
      $display("op=%0d A=%h B=%h req=%0d busy_cycles=%0d HI=%h LO=%h", op, a, b, rq, cyc, HI, LO);
   endtask

   initial begin
      reset = 1'b0; start = 1'b0; md_op = 4'd0; req = 1'b0; A = 32'd0; B = 32'd0;
      repeat (2) @(negedge clk);
      chk("reset_busy", {31'd0, busy}, 32'd0);
      chk("reset_hi", HI, 32'd0);
      chk("reset_lo", LO, 32'd0);
      reset = 1'b1;
      @(negedge clk);

      // MULT sign handling
      run_op(4'd1, 32'hFFFFFFFD, 32'd5, 1'b0, 1'b0);
      chk("mult_hi_const", HI, 32'hFFFFFFFF);
      chk("mult_lo_const", LO, 32'hFFFFFFF1);
      // divides
      run_op(4'd4, 32'd7, 32'd2, 1'b0, 1'b0);
      chk("divu_lo_const", LO, 32'd3);
      chk("divu_hi_const", HI, 32'd1);
      run_op(4'd3, 32'hFFFFFFF9, 32'd2, 1'b0, 1'b0);
      chk("div_lo_const", LO, 32'hFFFFFFFD);
      chk("div_hi_const", HI, 32'hFFFFFFFF);
      run_op(4'd3, 32'h80000000, 32'hFFFFFFFF, 1'b0, 1'b0);
      chk("div_ovf_lo", LO, 32'h80000000);
      chk("div_ovf_hi", HI, 32'd0);
      // divide by zero leaves HI/LO alone
      run_op(4'd5, 32'h11, 32'd0, 1'b0, 1'b0);
      run_op(4'd6, 32'h22, 32'd0, 1'b0, 1'b0);
      run_op(4'd3, 32'h1234, 32'd0, 1'b0, 1'b0);
      run_op(4'd4, 32'h5678, 32'd0, 1'b0, 1'b0);
      chk("div0_hi_const", HI, 32'h11);
      chk("div0_lo_const", LO, 32'h22);
      // MTHI flushed, then accepted
      run_op(4'd5, 32'hABCD, 32'd0, 1'b1, 1'b0);
      chk("mthi_req_hi", HI, 32'h11);
      run_op(4'd5, 32'hABCD, 32'd0, 1'b0, 1'b0);
      chk("mthi_hi_const", HI, 32'hABCD);
      // flushed MULT, unknown ops, and start/req during busy
      run_op(4'd1, 32'h7, 32'h9, 1'b1, 1'b0);
      run_op(4'd0, 32'h7, 32'h9, 1'b0, 1'b0);
      run_op(4'd15, 32'h7, 32'h9, 1'b0, 1'b0);
      run_op(4'd2, 32'hDEADBEEF, 32'hCAFEF00D, 1'b0, 1'b1);
      run_op(4'd3, 32'h9ABCDEF0, 32'h00001234, 1'b0, 1'b1);
      // MADDU accumulate (NONE when the feature is absent)
      run_op(4'd5, 32'd0, 32'd0, 1'b0, 1'b0);
      run_op(4'd6, 32'hFFFFFFFF, 32'd0, 1'b0, 1'b0);
      run_op(4'd8, 32'd1, 32'd1, 1'b0, 1'b0);
`ifdef MDU_MADD_EN
      chk("maddu_hi_const", HI, 32'd1);
      chk("maddu_lo_const", LO, 32'd0);
`else
      chk("maddu_off_hi", HI, 32'd0);
      chk("maddu_off_lo", LO, 32'hFFFFFFFF);
`endif
      run_op(4'd7, 32'hFFFFFFFF, 32'd3, 1'b0, 1'b0);

      // random ops
      for (int i = 0; i < 40; i++) begin
         logic [3:0]  op;
         logic [31:0] a, b;
         op = 4'($urandom_range(0, 9));
         a  = ($urandom_range(0, 7) == 0) ? 32'h80000000 : $urandom;
         b  = ($urandom_range(0, 5) == 0) ? 32'd0 :
              ($urandom_range(0, 5) == 0) ? 32'hFFFFFFFF : $urandom;
         run_op(op, a, b, 1'($urandom_range(0, 7) == 0), 1'($urandom_range(0, 1)));
      end

      // reset in the third busy cycle aborts the MULTU
      @(negedge clk);
      start = 1'b1; md_op = 4'd2; A = 32'hFFFFFFFF; B = 32'hFFFFFFFF; req = 1'b0;
      @(negedge clk);
      start = 1'b0; md_op = 4'd0;
      repeat (2) @(negedge clk);
      chk("abort_busy_before", {31'd0, busy}, 32'd1);
      reset = 1'b0;
      #1;
      chk("abort_busy", {31'd0, busy}, 32'd0);
      chk("abort_hi", HI, 32'd0);
      chk("abort_lo", LO, 32'd0);
      m_hi = 32'd0;
      m_lo = 32'd0;
      @(negedge clk);
      reset = 1'b1;
      repeat (8) @(negedge clk);
      chk("abort_late_busy", {31'd0, busy}, 32'd0);
      chk("abort_late_hi", HI, 32'd0);
      chk("abort_late_lo", LO, 32'd0);
      $display("reset abort: busy=%0d HI=%h LO=%h", busy, HI, LO);
      run_op(4'd1, 32'h12345678, 32'h9ABCDEF0, 1'b0, 1'b0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
